// File: rtl/range_pkg.sv
// Shared types and default constants for the auto-ranging frequency counter.
package range_pkg;

   // Width of the edge counter and of the reported reading.
   localparam int unsigned CNT_W = 14;

   // Default timing and scale constants (50 MHz system clock).
   localparam int unsigned GATE_CYCLES_DEF   = 50_000_000;
   localparam int unsigned FULL_SCALE_DEF    = 9999;
   localparam int unsigned LOW_SCALE_DEF     = 900;
   localparam int unsigned SETTLE_CYCLES_DEF = 1024;

   // Measurement FSM states.
   typedef enum logic [1:0] {
      GATE   = 2'd0,
      EVAL   = 2'd1,
      SETTLE = 2'd2
   } state_t;

   // Saturating increment for the edge counter: sticks at all-ones.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      logic [CNT_W-1:0] r;
      if (v == {CNT_W{1'b1}}) begin
         r = v;
      end else begin
         r = v + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      return r;
   endfunction

endpackage

// File: rtl/edge_sync.sv
// Brings the asynchronous ranged signal into the clk domain and turns each
// rising edge into a single-cycle pulse. A rise on din appears on pulse
// after two synchronizer flops; the third flop holds the previous level.
module edge_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic pulse
);

   logic sync1_r;
   logic sync2_r;
   logic prev_r;

   // Two-flop synchronizer followed by the previous-level register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_r <= 1'b0;
         sync2_r <= 1'b0;
         prev_r  <= 1'b0;
      end else begin
         sync1_r <= din;
         sync2_r <= sync1_r;
         prev_r  <= sync2_r;
      end
   end

   assign pulse = sync2_r & ~prev_r;

endmodule

// File: rtl/range_ctrl.sv
// Auto-ranging controller: counts synchronized rising edges of sigin over a
// fixed gate window, then either publishes the reading or switches the
// external divider between direct and /10 and waits for it to settle.
module range_ctrl
   import range_pkg::*;
#(
   parameter int unsigned GATE_CYCLES   = GATE_CYCLES_DEF,
   parameter int unsigned FULL_SCALE    = FULL_SCALE_DEF,
   parameter int unsigned LOW_SCALE     = LOW_SCALE_DEF,
   parameter int unsigned SETTLE_CYCLES = SETTLE_CYCLES_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             sigin,
   input  logic             manual_en,
   input  logic             manual_mode,
   output logic             modein,
   output logic [CNT_W-1:0] count,
   output logic             overflow,
   output logic             valid
);

   localparam int unsigned GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
   localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

   localparam logic [GW-1:0]    GATE_LAST   = GW'(GATE_CYCLES - 1);
   localparam logic [SW-1:0]    SETTLE_LAST = SW'(SETTLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] FULL_C      = CNT_W'(FULL_SCALE);
   localparam logic [CNT_W-1:0] LOW_C       = CNT_W'(LOW_SCALE);

   state_t           state_r;
   state_t           state_s;
   logic [GW-1:0]    gate_cnt_r;
   logic [GW-1:0]    gate_cnt_s;
   logic [SW-1:0]    settle_cnt_r;
   logic [SW-1:0]    settle_cnt_s;
   logic [CNT_W-1:0] edge_cnt_r;
   logic [CNT_W-1:0] edge_cnt_s;
   logic             modein_r;
   logic             modein_s;
   logic [CNT_W-1:0] count_r;
   logic [CNT_W-1:0] count_s;
   logic             overflow_r;
   logic             overflow_s;
   logic             valid_r;
   logic             valid_s;

   logic             edge_s;
   logic             range_chg_s;
   logic             over_s;
   logic             under_s;

   edge_sync u_edge_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .din   (sigin),
      .pulse (edge_s)
   );

   // A forced range that differs from the one currently driven is a range
   // change; dropping manual_en keeps modein, so it never causes one.
   assign range_chg_s = manual_en && (manual_mode != modein_r);
   assign over_s      = (edge_cnt_r > FULL_C);
   assign under_s     = (edge_cnt_r < LOW_C);

   // Next-state, counter and output computation for the measurement FSM.
   always_comb begin
      state_s      = state_r;
      gate_cnt_s   = gate_cnt_r;
      settle_cnt_s = settle_cnt_r;
      edge_cnt_s   = edge_cnt_r;
      modein_s     = modein_r;
      count_s      = count_r;
      overflow_s   = overflow_r;
      valid_s      = 1'b0;

      if (range_chg_s) begin
         // Manual range change aborts whatever is in progress (also restarts
         // an ongoing settle window).
         modein_s     = manual_mode;
         state_s      = SETTLE;
         gate_cnt_s   = '0;
         settle_cnt_s = '0;
         edge_cnt_s   = '0;
      end else begin
         case (state_r)
            GATE: begin
               if (edge_s) begin
                  edge_cnt_s = sat_inc(edge_cnt_r);
               end else begin
                  edge_cnt_s = edge_cnt_r;
               end
               if (gate_cnt_r == GATE_LAST) begin
                  state_s = EVAL;
               end else begin
                  gate_cnt_s = gate_cnt_r + {{(GW-1){1'b0}}, 1'b1};
               end
            end

            EVAL: begin
               gate_cnt_s   = '0;
               edge_cnt_s   = '0;
               settle_cnt_s = '0;
               if (!manual_en && over_s && !modein_r) begin
                  modein_s = 1'b1;
                  state_s  = SETTLE;
               end else if (!manual_en && under_s && modein_r) begin
                  modein_s = 1'b0;
                  state_s  = SETTLE;
               end else if (over_s) begin
                  count_s    = FULL_C;
                  overflow_s = 1'b1;
                  valid_s    = 1'b1;
                  state_s    = GATE;
               end else begin
                  count_s    = edge_cnt_r;
                  overflow_s = 1'b0;
                  valid_s    = 1'b1;
                  state_s    = GATE;
               end
            end

            SETTLE: begin
               gate_cnt_s = '0;
               edge_cnt_s = '0;
               if (settle_cnt_r == SETTLE_LAST) begin
                  settle_cnt_s = '0;
                  state_s      = GATE;
               end else begin
                  settle_cnt_s = settle_cnt_r + {{(SW-1){1'b0}}, 1'b1};
               end
            end

            default: begin
               state_s      = GATE;
               gate_cnt_s   = '0;
               settle_cnt_s = '0;
               edge_cnt_s   = '0;
            end
         endcase
      end
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= GATE;
         gate_cnt_r   <= '0;
         settle_cnt_r <= '0;
         edge_cnt_r   <= '0;
         modein_r     <= 1'b0;
         count_r      <= '0;
         overflow_r   <= 1'b0;
         valid_r      <= 1'b0;
      end else begin
         state_r      <= state_s;
         gate_cnt_r   <= gate_cnt_s;
         settle_cnt_r <= settle_cnt_s;
         edge_cnt_r   <= edge_cnt_s;
         modein_r     <= modein_s;
         count_r      <= count_s;
         overflow_r   <= overflow_s;
         valid_r      <= valid_s;
      end
   end

   assign modein   = modein_r;
   assign count    = count_r;
   assign overflow = overflow_r;
   assign valid    = valid_r;

endmodule

// File: doc/range_ctrl.md
# range_ctrl

Auto-ranging controller for the frequency meter. It is the driving end of the range-select interface: it counts rising edges of the ranged signal over a fixed gate window and drives `modein` of the range divider, selecting direct or ÷10 input. Each completed in-range gate produces a one-cycle `valid` with the reading. Readings taken just after a range change are discarded while the divider settles.

## Interface
- `GATE_CYCLES`, 50_000_000: gate window length in `clk` cycles (1 s at 50 MHz).
- `FULL_SCALE`, 9999: maximum displayable count. A count above this means up-range or overflow.
- `LOW_SCALE`, 900: a count below this in ÷10 mode means down-range. Must be < FULL_SCALE/10 (hysteresis).
- `SETTLE_CYCLES`, 1024: discard window after any range change.
- `clk`, input, 1: system clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `sigin`, input, 1: ranged signal from the range divider. Asynchronous to `clk`.
- `manual_en`, input, 1: 1 means range is forced by `manual_mode` and auto-switching is off.
- `manual_mode`, input, 1: forced range (0 = direct, 1 = ÷10).
- `modein`, output, 1: range select to the divider (0 = direct, 1 = ÷10).
- `count`, output, 14: last valid reading, range 0..FULL_SCALE.
- `overflow`, output, 1: last reading exceeded FULL_SCALE with no higher range available.
- `valid`, output, 1: one-cycle pulse when `count`/`overflow` update.

## Operation
- `sigin` passes through a 2-flop synchronizer plus a rising-edge detector. The result is a one-cycle `edge` pulse.
- Edge counter is 14 bits and saturates at 16383.
- FSM states:
  - **GATE**: gate counter runs 0..GATE_CYCLES-1. Each `edge` in this window increments the edge counter. On the last gate cycle, go to EVAL.
  - **EVAL** (1 cycle): let c = edge count, m = `modein`.
    - Auto mode, c > FULL_SCALE and m = 0: set `modein` = 1, go to SETTLE, no `valid`.
    - Auto mode, c < LOW_SCALE and m = 1: set `modein` = 0, go to SETTLE, no `valid`.
    - c > FULL_SCALE otherwise: `count` = FULL_SCALE, `overflow` = 1, `valid`, go to GATE.
    - Else: `count` = c, `overflow` = 0, `valid`, go to GATE.
    - On every exit from EVAL: clear the edge counter and gate counter.
  - **SETTLE**: wait SETTLE_CYCLES, counting nothing, then go to GATE with cleared counters.
- Manual mode:
  - While `manual_en` = 1, `modein` tracks `manual_mode`.
  - Any change of the effective range, from either `manual_en` or `manual_mode` toggling, aborts the current GATE or EVAL and enters SETTLE on the next cycle. No `valid` is produced for the aborted gate.
- Auto mode is re-entered keeping the current `modein` value.

## Timing
- Reset values:
  - `modein` = 0, `count` = 0, `overflow` = 0, `valid` = 0.
  - FSM = GATE, all counters 0, synchronizer flops 0.
- Reset is asynchronous. Asserting it mid-gate clears everything immediately. A fresh gate starts on the first clock after deassertion.
- Edge latency: a `sigin` rise reaches the counter 3 cycles later (2 sync flops plus edge register).
  - Edges detected in the last 3 cycles before EVAL are still counted if their `edge` pulse falls inside GATE.
  - Edges whose pulse arrives during EVAL or SETTLE are dropped.
- `count`, `overflow` and `valid` are registered. They change on the clock edge ending EVAL. `valid` is high exactly one cycle.
- `modein` changes on that same edge when ranging.
- Gate period with no range change is GATE_CYCLES + 1 cycles.
- Maximum countable `sigin` rate is `clk`/2.

## Structure
- Package `range_pkg`:
  - state enum {GATE, EVAL, SETTLE}.
  - Default constants for GATE_CYCLES, FULL_SCALE, LOW_SCALE, SETTLE_CYCLES.
  - Count width (14).
- Sub-module `edge_sync`: 2-flop synchronizer plus rising-edge pulse, with async active-low reset.
- The range divider itself is not instantiated here. The top level connects `modein` to it and its output back to `sigin`.

## Test plan
Bench parameters: GATE_CYCLES=1000, FULL_SCALE=99, LOW_SCALE=9, SETTLE_CYCLES=20. The bench closes the loop through a behavioural ÷10 divider controlled by `modein`.

- **Reset**: hold `rst_n` low with `sigin` toggling. Expect `modein` = 0, `count` = 0, `overflow` = 0, `valid` = 0. After release, the first `valid` occurs 1001 cycles later.
- **Direct range**: source period 20 clk. Expect `valid` with `count` = 50 (±1), `overflow` = 0, `modein` = 0, and repeated reads every 1001 cycles.
- **Up-range**: source period 4 clk.
  - First EVAL: `modein` goes to 1 with no `valid`.
  - After settle: `valid` with `count` = 25 (±1), `modein` = 1.
- **Down-range**: from the ÷10 state, change source period to 400 clk (0–1 divided edges). Expect `modein` = 0, no `valid`, then `count` = 2–3 with `valid`.
- **Manual overflow**: `manual_en` = 1, `manual_mode` = 0, source period 4 clk. Expect `count` = 99, `overflow` = 1, `valid`, `modein` stays 0. Toggling `manual_mode` mid-gate yields no `valid` for that gate.
- **Mid-gate reset**: pulse `rst_n` low at gate cycle 500. Expect outputs to clear immediately and no `valid` until 1001 cycles after release.
